// File: rtl/ex_mem_stage_pipe.sv
// Elastic EX/MEM boundary stage: a two-entry skid buffer with a registered in_ready and a synchronous flush.
// Optional statistics counters (stall_cnt, flush_cnt) are built only when PIPE_STAT_EN is defined.
module ex_mem_stage_pipe #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level
`ifdef PIPE_STAT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                in_ready_q;
  logic [CTRL_W-1:0]   main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0]   main_data_q, skid_data_q;
  logic                in_fire, out_fire;
  logic                load_main_in, load_main_skid, load_skid_in;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_d      = TWO;
            load_skid_in = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  // Data registers: main always feeds the outputs, skid only ever refills main.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl_q <= in_ctrl;
        main_data_q <= in_data;
      end else if (load_main_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_data_q <= skid_data_q;
      end
      if (load_skid_in) begin
        skid_ctrl_q <= in_ctrl;
        skid_data_q <= in_data;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign level     = state_q;

`ifdef PIPE_STAT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready) stall_cnt_q <= sat_inc(stall_cnt_q);
      // A flush that drops nothing is not counted.
      if (flush && (out_valid || in_fire)) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage_pipe.sv
// Self-checking bench for ex_mem_stage_pipe: directed scenarios plus random traffic against a queue model.
module tb_ex_mem_stage_pipe;

`ifdef PIPE_STAT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif
  localparam int CMAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [63:0] in_data, out_data;
  logic [1:0]  level;
`ifdef PIPE_STAT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0]  c;
    logic [63:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_last;
  bit          m_ready;
  int          m_stall, m_flush;

  ex_mem_stage_pipe #(.CTRL_W(8), .DATA_W(64), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .level(level)
`ifdef PIPE_STAT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // One clock edge; the queue model advances from the inputs present at that edge.
  task automatic tick();
    bit inf, outf;
    ent_t e;
    inf  = in_valid && m_ready;
    outf = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_last = '0; m_ready = 1'b1; m_stall = 0; m_flush = 0;
    end else begin
      if (mq.size() > 0 && !out_ready && m_stall < CMAX) m_stall++;
      if (flush) begin
        if ((mq.size() > 0 || inf) && m_flush < CMAX) m_flush++;
        mq.delete();
      end else begin
        if (outf) void'(mq.pop_front());
        if (inf) begin
          e.c = in_ctrl; e.d = in_data;
          mq.push_back(e);
        end
      end
      if (mq.size() > 0) m_last = mq[0].d;
      m_ready = (mq.size() < 2);
    end
    #1;
  endtask

  function automatic logic [7:0] exp_ctrl();
    return (mq.size() > 0) ? mq[0].c : 8'h00;
  endfunction

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 64'hFF; in_ctrl = 8'hFF;
    flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_ctrl !== 8'h00) begin n_fail++; $display("FAIL reset_out_ctrl got %0h want 0", out_ctrl); end
    n_cmp++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data got %0h want 0", out_data); end
    n_cmp++; if (level !== 2'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 64'(i); in_ctrl = 8'(i);
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 64'(i) || out_ctrl !== 8'(i) || level !== 2'd1 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_%0d got v=%0b d=%0h c=%0h lvl=%0d rdy=%0b want v=1 d=%0h lvl=1 rdy=1",
                 i, out_valid, out_data, out_ctrl, level, in_ready, i);
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [63:0] want_d[3] = '{64'hA1, 64'hB2, 64'hC3};
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hA1; in_ctrl = 8'h01;
    tick();
    n_cmp++; if (level !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first got lvl=%0d rdy=%0b want 1/1", level, in_ready); end
    in_data = 64'hB2; in_ctrl = 8'h02;
    tick();
    n_cmp++; if (level !== 2'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got lvl=%0d rdy=%0b want 2/0", level, in_ready); end
    in_data = 64'hC3; in_ctrl = 8'h03;
    tick(); tick();
    n_cmp++; if (level !== 2'd2 || out_data !== 64'hA1) begin n_fail++; $display("FAIL bp_hold got lvl=%0d d=%0h want 2/a1", level, out_data); end
    out_ready = 1'b1;
    for (int k = 1; k < 3; k++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== want_d[k] || out_data !== m_last) begin
        n_fail++;
        $display("FAIL bp_order_%0d got v=%0b d=%0h want v=1 d=%0h", k, out_valid, out_data, want_d[k]);
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || level !== 2'd0) begin n_fail++; $display("FAIL bp_empty got v=%0b lvl=%0d want 0/0", out_valid, level); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h11; in_ctrl = 8'h11; tick();
    in_data = 64'h22; in_ctrl = 8'h22; tick();
    in_data = 64'hDD; in_ctrl = 8'hDD; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || level !== 2'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state got v=%0b c=%0h lvl=%0d rdy=%0b want 0/0/0/1", out_valid, out_ctrl, level, in_ready);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_D_%0d got v=%0b d=%0h want v=0", k, out_valid, out_data); end
    end
  endtask

  task automatic test_bubble();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ctrl = 8'hA5; in_data = 64'h5A5A;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_ctrl !== 8'hA5) begin n_fail++; $display("FAIL bubble_live got v=%0b c=%0h want 1/a5", out_valid, out_ctrl); end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 64'h5A5A) begin
      n_fail++; $display("FAIL bubble_gate got v=%0b c=%0h d=%0h want 0/00/5a5a", out_valid, out_ctrl, out_data);
    end
    tick();
    n_cmp++; if (out_ctrl !== 8'h00 || out_data !== 64'h5A5A) begin
      n_fail++; $display("FAIL bubble_hold got c=%0h d=%0h want 00/5a5a", out_ctrl, out_data);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_ctrl   = 8'($urandom);
      in_data   = {32'($urandom), 32'($urandom)};
      tick();
      n_cmp++;
      if (out_valid !== (mq.size() > 0) || level !== 2'(mq.size()) || in_ready !== m_ready) begin
        n_fail++;
        $display("FAIL rand_ctl_%0d got v=%0b lvl=%0d rdy=%0b want v=%0b lvl=%0d rdy=%0b",
                 i, out_valid, level, in_ready, mq.size() > 0, mq.size(), m_ready);
      end
      n_cmp++;
      if (out_data !== m_last || out_ctrl !== exp_ctrl()) begin
        n_fail++;
        $display("FAIL rand_dat_%0d got d=%0h c=%0h want d=%0h c=%0h", i, out_data, out_ctrl, m_last, exp_ctrl());
      end
`ifdef PIPE_STAT_EN
      n_cmp++;
      if (stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush)) begin
        n_fail++;
        $display("FAIL rand_cnt_%0d got s=%0d f=%0d want s=%0d f=%0d", i, stall_cnt, flush_cnt, m_stall, m_flush);
      end
`endif
    end
    reset = 1'b0; flush = 1'b0;
  endtask

`ifdef PIPE_STAT_EN
  task automatic test_stats();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h77; in_ctrl = 8'h07;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    n_cmp++; if (stall_cnt !== 2'd3) begin n_fail++; $display("FAIL stat_stall_sat got %0d want 3", stall_cnt); end
    n_cmp++; if (flush_cnt !== 2'd0) begin n_fail++; $display("FAIL stat_flush_zero got %0d want 0", flush_cnt); end
    flush = 1'b1;
    tick();
    n_cmp++; if (flush_cnt !== 2'd1) begin n_fail++; $display("FAIL stat_flush_one got %0d want 1", flush_cnt); end
    tick();
    flush = 1'b0;
    n_cmp++; if (flush_cnt !== 2'd1) begin n_fail++; $display("FAIL stat_flush_idle got %0d want 1", flush_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    mq.delete(); m_last = '0; m_ready = 1'b1; m_stall = 0; m_flush = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble();
    test_random();
`ifdef PIPE_STAT_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
